// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_DW = 16;
  localparam int unsigned DIV_VW = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // All-ones quotient reported on divide-by-zero, sized by the caller.
  function automatic logic [63:0] DZ_QUOTIENT(input int unsigned width);
    logic [63:0] ones;
    ones = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < width) ones[i] = 1'b1;
    end
    return ones;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int unsigned VW = 8
) (
  input  logic [VW:0]   r,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   r_next,
  output logic          q_bit
);

  logic [VW+1:0] r_shift;

  always_comb begin
    r_shift = {r, bit_in};
    q_bit   = (r_shift >= {2'b00, divisor});
    r_next  = q_bit ? (VW+1)'(r_shift - {2'b00, divisor}) : (VW+1)'(r_shift);
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [DW-1:0] DzQuotient = DW'(DZ_QUOTIENT(DW));

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   rem_q, rem_d;
  logic [DW-1:0] dvd_q, dvd_d;      // dividend shifts out the top, quotient shifts in below
  logic [VW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] remo_q, remo_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   step_r;
  logic          step_q;
  logic [DW-1:0] mag_dividend, final_quo;
  logic [VW-1:0] mag_divisor, final_rem;

  div_step #(
    .VW(VW)
  ) u_step (
    .r      (rem_q),
    .bit_in (dvd_q[DW-1]),
    .divisor(dvs_q),
    .r_next (step_r),
    .q_bit  (step_q)
  );

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  always_comb begin
    mag_dividend = dividend[DW-1] ? -dividend : dividend;
    mag_divisor  = divisor[VW-1] ? -divisor : divisor;
    final_quo    = {dvd_q[DW-2:0], step_q};
    final_rem    = step_r[VW-1:0];
    if (neg_q_q) final_quo = -final_quo;
    if (neg_r_q) final_rem = -final_rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if ((state_q != RUN) && start) begin
      neg_q_d = dividend[DW-1] ^ divisor[VW-1];
      neg_r_d = dividend[DW-1];
    end
  end
`else
  always_comb begin
    mag_dividend = dividend;
    mag_divisor  = divisor;
    final_quo    = {dvd_q[DW-2:0], step_q};
    final_rem    = step_r[VW-1:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = DzQuotient;
            remo_d  = dividend[VW-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = mag_dividend;
            dvs_d   = mag_divisor;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d = step_r;
        dvd_d = {dvd_q[DW-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          quo_d   = final_quo;
          remo_d  = final_rem;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready       = (state_q != RUN);
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule
